// File: rtl/frame_luma_gate.sv
// frame_luma_gate
// Whole-frame luma statistics. Accumulates gray_i over de_i pixels, closes the
// frame on the rising edge of vs_i, and divides sum by count with an 8-step
// restoring divider. The frame mean drives a multi-frame hysteresis that
// produces a frame-stable "scene is bright" flag.
// Optional per-frame min/max outputs are built when LUMA_MINMAX_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_ACCUM  | idle; only the pixel accumulators run
// ST_DIV    | restoring division, one quotient bit per cycle, MSB first
// ST_UPDATE | result cycle; outputs show the committed frame result
//
// The accumulators run in every state, so the next frame is collected while
// the previous one is being divided.
module frame_luma_gate #(
   parameter int HP      = 1920,
   parameter int VP      = 1080,
   parameter int THR_HI  = 160,
   parameter int THR_LO  = 96,
   parameter int NFRAMES = 4
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       vs_i,
   input  logic       de_i,
   input  logic [7:0] gray_i,
   output logic [7:0] mean_o,
   output logic       mean_valid_o,
   output logic       bright_o,
   output logic       geom_err_o,
   output logic       overrun_o
`ifdef LUMA_MINMAX_EN
   ,
   output logic [7:0] min_o,
   output logic [7:0] max_o
`endif
);

   localparam int NPIX = HP * VP;
   localparam int SW   = $clog2(NPIX * 255 + 1);
   localparam int CW   = $clog2(NPIX + 1);
   // Divider datapath is wide enough to hold the divisor shifted left by 8.
   localparam int DW   = SW + 8;

   localparam logic [CW-1:0] NPIX_C   = CW'(NPIX);
   localparam logic [7:0]    THR_HI_C = 8'(THR_HI);
   localparam logic [7:0]    THR_LO_C = 8'(THR_LO);
   localparam logic [3:0]    NFR_C    = 4'(NFRAMES);

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DIV    = 2'd1,
      ST_UPDATE = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic          r_vs_q;
   logic          w_frame_end;

   logic [SW-1:0] r_sum;
   logic [SW:0]   w_sum_ext;
   logic [SW-1:0] w_sum_inc;
   logic [CW-1:0] r_cnt;
   logic [CW:0]   w_cnt_ext;
   logic [CW-1:0] w_cnt_inc;

   logic [SW-1:0] r_rem;
   logic [CW-1:0] r_div;
   logic [7:0]    r_q;
   logic [2:0]    r_step;
   logic          r_qsat;
   logic          w_sat_chk;
   logic [DW-1:0] w_shifted;
   logic          w_fit;
   logic [7:0]    w_q_nxt;
   logic [7:0]    w_mean;

   logic          w_load;
   logic          w_commit_div;
   logic          w_commit_zero;
   logic          w_busy;
   logic          w_qualify;
   logic [3:0]    r_streak;

   assign w_frame_end = vs_i & ~r_vs_q;
   assign w_busy      = (r_state != ST_ACCUM);

   // Saturating next values of the running sum and pixel count.
   assign w_sum_ext = {1'b0, r_sum} + {{(SW-7){1'b0}}, gray_i};
   assign w_cnt_ext = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};

   always_comb begin
      w_sum_inc = r_sum;
      w_cnt_inc = r_cnt;
      if (de_i) begin
         w_sum_inc = w_sum_ext[SW] ? {SW{1'b1}} : w_sum_ext[SW-1:0];
         w_cnt_inc = w_cnt_ext[CW] ? {CW{1'b1}} : w_cnt_ext[CW-1:0];
      end
   end

   // A quotient of 256 or more is only reachable once the counters saturate;
   // it is flagged at snapshot time and clamped to 255.
   assign w_sat_chk = ({8'd0, w_sum_inc} >= ({{(DW-CW){1'b0}}, w_cnt_inc} << 8));

   // One restoring step: try to subtract divisor << step from the remainder.
   assign w_shifted = {{(DW-CW){1'b0}}, r_div} << r_step;
   assign w_fit     = ({8'd0, r_rem} >= w_shifted);
   assign w_q_nxt   = r_q | (w_fit ? (8'd1 << r_step) : 8'd0);
   assign w_mean    = r_qsat ? 8'hFF : w_q_nxt;

   assign w_qualify = bright_o ? (w_mean <= THR_LO_C) : (w_mean >= THR_HI_C);

   // Frame-end edge detector on vs_i.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_vs_q <= 1'b0;
      end else begin
         r_vs_q <= vs_i;
      end
   end

   // Pixel accumulators; cleared at frame end after the snapshot.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_sum <= '0;
         r_cnt <= '0;
      end else if (w_frame_end) begin
         r_sum <= '0;
         r_cnt <= '0;
      end else begin
         r_sum <= w_sum_inc;
         r_cnt <= w_cnt_inc;
      end
   end

   // FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= ST_ACCUM;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state; a frame end in any state restarts the divider.
   always_comb begin
      w_state_nxt   = r_state;
      w_load        = 1'b0;
      w_commit_div  = 1'b0;
      w_commit_zero = 1'b0;
      if (w_frame_end) begin
         w_load = 1'b1;
         if (w_cnt_inc == '0) begin
            w_state_nxt   = ST_UPDATE;
            w_commit_zero = 1'b1;
         end else begin
            w_state_nxt = ST_DIV;
         end
      end else begin
         case (r_state)
            ST_ACCUM: w_state_nxt = ST_ACCUM;
            ST_DIV: begin
               if (r_step == 3'd0) begin
                  w_state_nxt  = ST_UPDATE;
                  w_commit_div = 1'b1;
               end
            end
            ST_UPDATE: w_state_nxt = ST_ACCUM;
            default:   w_state_nxt = ST_ACCUM;
         endcase
      end
   end

   // Divider: snapshot at frame end, then one quotient bit per DIV cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rem  <= '0;
         r_div  <= '0;
         r_q    <= '0;
         r_step <= '0;
         r_qsat <= 1'b0;
      end else if (w_load) begin
         r_rem  <= w_sum_inc;
         r_div  <= w_cnt_inc;
         r_q    <= '0;
         r_step <= 3'd7;
         r_qsat <= w_sat_chk;
      end else if (r_state == ST_DIV) begin
         if (w_fit) begin
            r_rem <= r_rem - w_shifted[SW-1:0];
         end
         r_q    <= w_q_nxt;
         r_step <= r_step - 3'd1;
      end
   end

   // Result commit, geometry check and bright hysteresis.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mean_o       <= '0;
         mean_valid_o <= 1'b0;
         geom_err_o   <= 1'b0;
         bright_o     <= 1'b0;
         r_streak     <= '0;
      end else begin
         mean_valid_o <= 1'b0;
         geom_err_o   <= 1'b0;
         if (w_commit_div) begin
            mean_o       <= w_mean;
            mean_valid_o <= 1'b1;
            if (r_div != NPIX_C) begin
               geom_err_o <= 1'b1;
            end else if (w_qualify) begin
               if (r_streak + 4'd1 == NFR_C) begin
                  bright_o <= ~bright_o;
                  r_streak <= '0;
               end else begin
                  r_streak <= r_streak + 4'd1;
               end
            end else begin
               r_streak <= '0;
            end
         end else if (w_commit_zero) begin
            geom_err_o <= 1'b1;
         end
      end
   end

   // Sticky flag: a frame closed while the previous result was still pending.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overrun_o <= 1'b0;
      end else if (w_frame_end && w_busy) begin
         overrun_o <= 1'b1;
      end
   end

`ifdef LUMA_MINMAX_EN
   logic [7:0] r_min;
   logic [7:0] r_max;
   logic [7:0] w_min_inc;
   logic [7:0] w_max_inc;
   logic [7:0] r_min_snap;
   logic [7:0] r_max_snap;

   assign w_min_inc = (de_i && (gray_i < r_min)) ? gray_i : r_min;
   assign w_max_inc = (de_i && (gray_i > r_max)) ? gray_i : r_max;

   // Per-frame min/max trackers, re-armed at every frame end.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_min <= 8'hFF;
         r_max <= 8'h00;
      end else if (w_frame_end) begin
         r_min <= 8'hFF;
         r_max <= 8'h00;
      end else begin
         r_min <= w_min_inc;
         r_max <= w_max_inc;
      end
   end

   // Hold the closed frame's extremes while the divider runs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_min_snap <= '0;
         r_max_snap <= '0;
      end else if (w_load) begin
         r_min_snap <= w_min_inc;
         r_max_snap <= w_max_inc;
      end
   end

   // Publish min/max together with the frame result.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         min_o <= '0;
         max_o <= '0;
      end else if (w_commit_div) begin
         min_o <= r_min_snap;
         max_o <= r_max_snap;
      end else if (w_commit_zero) begin
         min_o <= w_min_inc;
         max_o <= w_max_inc;
      end
   end
`endif

endmodule

// File: tb/tb_frame_luma_gate.sv
`timescale 1ns/1ps
module tb_frame_luma_gate;
   localparam int HP      = 4;
   localparam int VP      = 2;
   localparam int THR_HI  = 160;
   localparam int THR_LO  = 96;
   localparam int NFRAMES = 2;
   localparam int NPIX    = HP * VP;
   localparam int SMAX    = (1 << $clog2(NPIX * 255 + 1)) - 1;
   localparam int CMAX    = (1 << $clog2(NPIX + 1)) - 1;

   logic       clk_i  = 1'b0;
   logic       rst_ni = 1'b0;
   logic       vs_i   = 1'b0;
   logic       de_i   = 1'b0;
   logic [7:0] gray_i = 8'd0;
   logic [7:0] mean_o;
   logic       mean_valid_o;
   logic       bright_o;
   logic       geom_err_o;
   logic       overrun_o;
`ifdef LUMA_MINMAX_EN
   logic [7:0] min_o;
   logic [7:0] max_o;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit checking = 1'b0;
   int px_q[$];

   frame_luma_gate #(
      .HP(HP), .VP(VP), .THR_HI(THR_HI), .THR_LO(THR_LO), .NFRAMES(NFRAMES)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .vs_i(vs_i),
      .de_i(de_i),
      .gray_i(gray_i),
      .mean_o(mean_o),
      .mean_valid_o(mean_valid_o),
      .bright_o(bright_o),
      .geom_err_o(geom_err_o),
      .overrun_o(overrun_o)
`ifdef LUMA_MINMAX_EN
      ,
      .min_o(min_o),
      .max_o(max_o)
`endif
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit m_vs_q = 0;
   int m_px[$];
   int m_cyc = 0;
   int m_busy_until = -1;
   int m_due = 0;
   bit m_pend = 0;
   int p_mean, p_cnt, p_min, p_max;
   int m_streak = 0;
   int e_mean = 0, e_min = 0, e_max = 0;
   bit e_valid = 0, e_geom = 0, e_bright = 0, e_over = 0;

   task automatic model_reset();
      m_vs_q = 0; m_px.delete(); m_busy_until = -1; m_pend = 0; m_streak = 0;
      e_mean = 0; e_min = 0; e_max = 0;
      e_valid = 0; e_geom = 0; e_bright = 0; e_over = 0;
   endtask

   task automatic model_step();
      bit fe;
      int s, c, mn, mx;
      m_cyc++;
      fe = vs_i && !m_vs_q;
      m_vs_q = vs_i;
      e_valid = 0;
      e_geom  = 0;
      if (de_i) m_px.push_back(int'(gray_i));
      if (fe) begin
         if (m_cyc <= m_busy_until) e_over = 1;
         s = 0; mn = 255; mx = 0;
         foreach (m_px[i]) begin
            s += m_px[i];
            if (m_px[i] < mn) mn = m_px[i];
            if (m_px[i] > mx) mx = m_px[i];
         end
         c = m_px.size();
         m_px.delete();
         if (s > SMAX) s = SMAX;
         if (c > CMAX) c = CMAX;
         if (c == 0) begin
            e_geom = 1; e_min = 255; e_max = 0;
            m_pend = 0; m_busy_until = m_cyc + 1;
         end else begin
            m_pend = 1; m_due = m_cyc + 8; m_busy_until = m_cyc + 9;
            p_mean = (s / c > 255) ? 255 : s / c;
            p_cnt = c; p_min = mn; p_max = mx;
         end
      end else if (m_pend && m_cyc == m_due) begin
         m_pend = 0;
         e_valid = 1; e_mean = p_mean; e_min = p_min; e_max = p_max;
         if (p_cnt != NPIX) e_geom = 1;
         else begin
            if (e_bright ? (p_mean <= THR_LO) : (p_mean >= THR_HI)) m_streak++;
            else m_streak = 0;
            if (m_streak == NFRAMES) begin
               e_bright = !e_bright;
               m_streak = 0;
            end
         end
      end
   endtask

   initial begin : model
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni) model_reset();
         else model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin : cmp
      forever begin
         @(negedge clk_i);
         if (checking) begin
            chk("cyc_mean_o", mean_o, e_mean);
            chk("cyc_mean_valid_o", mean_valid_o, e_valid);
            chk("cyc_bright_o", bright_o, e_bright);
            chk("cyc_geom_err_o", geom_err_o, e_geom);
            chk("cyc_overrun_o", overrun_o, e_over);
`ifdef LUMA_MINMAX_EN
            chk("cyc_min_o", min_o, e_min);
            chk("cyc_max_o", max_o, e_max);
`endif
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input bit vs, input bit de, input int g);
      vs_i = vs; de_i = de; gray_i = 8'(g);
      @(posedge clk_i);
      #1;
   endtask

   task automatic fill(input int g, input int n);
      px_q.delete();
      repeat (n) px_q.push_back(g);
   endtask

   task automatic send_frame(input bit coincide, output int e);
      int n;
      n = px_q.size();
      for (int i = 0; i < n; i++) begin
         if (coincide && i == n - 1) tick(1, 1, px_q[i]);
         else tick(0, 1, px_q[i]);
      end
      if (!coincide || n == 0) tick(1, 0, 0);
      e = cyc;
   endtask

   task automatic wait_result(input int e, input int lat, input int m, input int v,
                              input int g, input int b);
      bit seen;
      int k;
      seen = 0; k = 0;
      while (!seen && k < 20) begin
         if (mean_valid_o || geom_err_o) seen = 1;
         else begin
            tick(0, 0, 0);
            k++;
         end
      end
      chk("result_seen", seen, 1);
      chk("latency", cyc - e + 1, lat);
      chk("mean_o", mean_o, m);
      chk("mean_valid_o", mean_valid_o, v);
      chk("geom_err_o", geom_err_o, g);
      chk("bright_o", bright_o, b);
      repeat (3) tick(0, 0, 0);
   endtask

   task automatic run_frame(input bit coin, input int m, input int v, input int g,
                            input int lat, input int b);
      int e;
      send_frame(coin, e);
      wait_result(e, lat, m, v, g, b);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int e, e2, pulses, len, cls, lo, hi, gap;
      bit coin;
      repeat (2) @(posedge clk_i);
      #1;
      checking = 1;

      for (int i = 0; i < 6; i++) tick(0, i[0], 17 * i + 3);
      chk("rst_mean_o", mean_o, 0);
      chk("rst_valid", mean_valid_o, 0);
      chk("rst_bright", bright_o, 0);
      chk("rst_overrun", overrun_o, 0);
      rst_ni = 1'b1;
      repeat (2) tick(0, 0, 0);

      fill(100, 8);  run_frame(0, 100, 1, 0, 9, 0);
      px_q = '{0, 255, 255, 255, 255, 0, 0, 0};
      run_frame(0, 127, 1, 0, 9, 0);
      px_q = '{0, 255, 255, 255, 255, 0, 0, 0};
      run_frame(1, 127, 1, 0, 9, 0);

      fill(200, 8); run_frame(0, 200, 1, 0, 9, 0);
      fill(200, 8); run_frame(0, 200, 1, 0, 9, 1);
      fill(128, 8); run_frame(0, 128, 1, 0, 9, 1);
      fill(50, 8);  run_frame(0, 50, 1, 0, 9, 1);
      fill(128, 8); run_frame(0, 128, 1, 0, 9, 1);
      fill(50, 8);  run_frame(0, 50, 1, 0, 9, 1);
      fill(50, 8);  run_frame(0, 50, 1, 0, 9, 0);

      fill(200, 8); run_frame(0, 200, 1, 0, 9, 0);
      fill(255, 7); run_frame(0, 255, 1, 1, 9, 0);
      fill(200, 8); run_frame(0, 200, 1, 0, 9, 1);
      px_q.delete(); run_frame(0, 200, 0, 1, 1, 1);

      fill(80, 8);
      send_frame(0, e);
      tick(0, 1, 200); tick(0, 1, 200); tick(0, 1, 100);
      tick(1, 0, 0);
      e2 = cyc;
      chk("overrun_edge_gap", e2 - e, 4);
      chk("overrun_set", overrun_o, 1);
      wait_result(e2, 9, 166, 1, 1, 1);
      repeat (5) tick(0, 0, 0);
      chk("overrun_sticky", overrun_o, 1);

      fill(100, 8);
      send_frame(0, e);
      repeat (3) tick(0, 0, 0);
      #2 rst_ni = 1'b0;
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         tick(0, 0, 0);
         if (mean_valid_o) pulses++;
      end
      chk("no_pulse_after_reset", pulses, 0);
      chk("reset_mean_o", mean_o, 0);
      chk("reset_overrun", overrun_o, 0);
      chk("reset_bright", bright_o, 0);

      for (int f = 0; f < 150; f++) begin
         cls = $urandom_range(0, 2);
         len = ($urandom_range(0, 9) < 7) ? 8 : $urandom_range(0, 20);
         lo = (cls == 0) ? 170 : 0;
         hi = (cls == 1) ? 90 : 255;
         coin = 0;
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) tick(0, 0, $urandom_range(0, 255));
            coin = (i == len - 1) && ($urandom_range(0, 1) == 1);
            tick(coin, 1, $urandom_range(lo, hi));
         end
         if (!coin) tick(1, 0, 0);
         gap = ($urandom_range(0, 9) < 7) ? 11 : $urandom_range(1, 9);
         repeat (gap) tick(0, 0, $urandom_range(0, 255));
      end
      repeat (12) tick(0, 0, 0);

`ifdef LUMA_MINMAX_EN
      rst_ni = 1'b0;
      tick(0, 0, 0);
      rst_ni = 1'b1;
      tick(0, 0, 0);
      px_q = '{50, 3, 120, 200, 77, 9, 199, 100};
      send_frame(0, e);
      wait_result(e, 9, 94, 1, 0, 0);
      chk("min_o", min_o, 3);
      chk("max_o", max_o, 200);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
